// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and constants for the enemy squad
// Contents:
//   enemy_state_t  per-enemy life cycle: ALIVE -> HIT -> DEAD
//   LCG_MUL/INC    constants of the 32-bit linear congruential generator
package enemy_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } enemy_state_t;

  localparam logic [31:0] LCG_MUL = 32'd1103515245;
  localparam logic [31:0] LCG_INC = 32'd12345;

endpackage

// File: rtl/enemy_unit.sv
// rtl/enemy_unit.sv - one enemy: life-cycle FSM, vertical position and timers
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   tick                movement tick (one-cycle pulse)
//   dir                 direction request for this tick: 0 = row+1, 1 = row-1
//   hit_valid/row/col   player shot strobe and target cell
//   row, col            current cell (col is fixed)
//   alive, hit          registered: drawn / blinking
//   match               this cycle's shot lands on this ALIVE enemy
//   dead_next           enemy will be DEAD after this edge
// Optional: ENEMY_RESPAWN_EN adds RESPAWN_TICKS and the respawn timer.
module enemy_unit #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int HIT_TICKS = 2,
`ifdef ENEMY_RESPAWN_EN
  parameter int RESPAWN_TICKS = 8,
`endif
  parameter int IDX       = 0,
  localparam int ROW_W    = $clog2(ROWS),
  localparam int COL_W    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             dir,
  input  logic             hit_valid,
  input  logic [ROW_W-1:0] hit_row,
  input  logic [COL_W-1:0] hit_col,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             alive,
  output logic             hit,
  output logic             match,
  output logic             dead_next
);
  import enemy_pkg::*;

  localparam logic [ROW_W-1:0] ROW_RST  = ROW_W'(1 + (IDX % (ROWS - 2)));
  localparam logic [ROW_W-1:0] ROW_TOP  = ROW_W'(ROWS - 2);
  localparam logic [ROW_W-1:0] ROW_BOT  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_FIX  = COL_W'(1 + (IDX % (COLS - 2)));
  localparam logic [7:0]       HIT_LAST = 8'(HIT_TICKS - 1);

  enemy_state_t     state, state_nxt;
  logic [ROW_W-1:0] row_nxt, row_moved;
  logic [7:0]       hit_cnt, hit_cnt_nxt;
`ifdef ENEMY_RESPAWN_EN
  localparam logic [7:0] RESP_LAST = 8'(RESPAWN_TICKS - 1);
  logic [7:0]       resp_cnt, resp_cnt_nxt;
`endif

  assign col   = COL_FIX;
  // Compared against the pre-move row, so a shot always hits where the enemy is drawn.
  assign match = hit_valid && (state == ALIVE) && (hit_row == row) && (hit_col == col);

  // Rows 0 and ROWS-1 stay empty: requests toward them bounce back.
  always_comb begin
    row_moved = row;
    if (!dir) row_moved = (row == ROW_TOP) ? row - ROW_W'(1) : row + ROW_W'(1);
    else      row_moved = (row == ROW_BOT) ? row + ROW_W'(1) : row - ROW_W'(1);
  end

  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    hit_cnt_nxt = hit_cnt;
`ifdef ENEMY_RESPAWN_EN
    resp_cnt_nxt = resp_cnt;
`endif
    case (state)
      ALIVE: begin
        // A shot takes priority over movement in the same cycle.
        if (match) begin
          state_nxt   = HIT;
          hit_cnt_nxt = '0;
        end else if (tick) begin
          row_nxt = row_moved;
        end
      end
      HIT: begin
        if (tick) begin
          if (hit_cnt == HIT_LAST) begin
            state_nxt = DEAD;
`ifdef ENEMY_RESPAWN_EN
            resp_cnt_nxt = '0;
`endif
          end else begin
            hit_cnt_nxt = hit_cnt + 8'd1;
          end
        end
      end
      DEAD: begin
`ifdef ENEMY_RESPAWN_EN
        if (tick) begin
          if (resp_cnt == RESP_LAST) begin
            state_nxt = ALIVE;
            row_nxt   = ROW_RST;
          end else begin
            resp_cnt_nxt = resp_cnt + 8'd1;
          end
        end
`endif
      end
      default: state_nxt = ALIVE;
    endcase
  end

  assign dead_next = (state_nxt == DEAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ALIVE;
      row     <= ROW_RST;
      hit_cnt <= '0;
      alive   <= 1'b1;
      hit     <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
      resp_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      hit_cnt <= hit_cnt_nxt;
      alive   <= (state_nxt != DEAD);
      hit     <= (state_nxt == HIT);
`ifdef ENEMY_RESPAWN_EN
      resp_cnt <= resp_cnt_nxt;
`endif
    end
  end

endmodule

// File: rtl/enemy_squad.sv
// rtl/enemy_squad.sv - squad of N_ENEMY enemies with tick divider, PRNG and kill counter
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   hit_valid/row/col      one-cycle player shot at a grid cell
//   tick                   one-cycle pulse every TICK_DIV cycles
//   enemy_row/enemy_col    packed positions, enemy i at slice i
//   enemy_alive/enemy_hit  per-enemy drawn / blinking flags
//   kill_count             enemies that entered HIT since reset, saturating at 255
//   all_dead               every enemy is DEAD
// Optional: ENEMY_RESPAWN_EN makes dead enemies return after RESPAWN_TICKS ticks.
module enemy_squad #(
  parameter int          N_ENEMY   = 4,
  parameter int          ROWS      = 8,
  parameter int          COLS      = 8,
  parameter int          TICK_DIV  = 12500000,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          HIT_TICKS = 2,
`ifdef ENEMY_RESPAWN_EN
  parameter int          RESPAWN_TICKS = 8,
`endif
  localparam int         ROW_W     = $clog2(ROWS),
  localparam int         COL_W     = $clog2(COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hit_valid,
  input  logic [ROW_W-1:0]         hit_row,
  input  logic [COL_W-1:0]         hit_col,
  output logic                     tick,
  output logic [N_ENEMY*ROW_W-1:0] enemy_row,
  output logic [N_ENEMY*COL_W-1:0] enemy_col,
  output logic [N_ENEMY-1:0]       enemy_alive,
  output logic [N_ENEMY-1:0]       enemy_hit,
  output logic [7:0]               kill_count,
  output logic                     all_dead
);
  import enemy_pkg::*;

  localparam int             CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   cnt;
  logic [31:0]        rnd;
  logic [N_ENEMY-1:0] match;
  logic [N_ENEMY-1:0] dead_next;
  logic [3:0]         n_match;
  logic [8:0]         kill_sum;

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    enemy_unit #(
      .ROWS(ROWS),
      .COLS(COLS),
      .HIT_TICKS(HIT_TICKS),
`ifdef ENEMY_RESPAWN_EN
      .RESPAWN_TICKS(RESPAWN_TICKS),
`endif
      .IDX(i)
    ) u_unit (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .dir(rnd[16+i]),
      .hit_valid(hit_valid),
      .hit_row(hit_row),
      .hit_col(hit_col),
      .row(enemy_row[i*ROW_W +: ROW_W]),
      .col(enemy_col[i*COL_W +: COL_W]),
      .alive(enemy_alive[i]),
      .hit(enemy_hit[i]),
      .match(match[i]),
      .dead_next(dead_next[i])
    );
  end

  always_comb begin
    n_match = '0;
    for (int i = 0; i < N_ENEMY; i++) n_match = n_match + 4'(match[i]);
    kill_sum = {1'b0, kill_count} + 9'(n_match);
  end

  // tick is the registered wrap strobe; enemies and the PRNG act on the cycle it is high,
  // so the directions they read are the pre-update rnd value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      tick       <= 1'b0;
      rnd        <= SEED;
      kill_count <= 8'd0;
      all_dead   <= 1'b0;
    end else begin
      tick       <= (cnt == CNT_LAST);
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      if (tick) rnd <= rnd * LCG_MUL + LCG_INC;
      kill_count <= kill_sum[8] ? 8'hFF : kill_sum[7:0];
      all_dead   <= &dead_next;
    end
  end

endmodule

// File: tb/tb_enemy_squad.sv
// tb/tb_enemy_squad.sv - directed self-checking bench for enemy_squad
module tb_enemy_squad;

  logic        clk;
  logic        rst;
  logic        hit_valid;
  logic [2:0]  hit_row;
  logic [1:0]  hit_col;
  logic        tick;
  logic [11:0] enemy_row;
  logic [7:0]  enemy_col;
  logic [3:0]  enemy_alive;
  logic [3:0]  enemy_hit;
  logic [7:0]  kill_count;
  logic        all_dead;

  int n_checks = 0;
  int n_pass   = 0;

  // ROWS=6 puts enemy 3 (row 4) on the top bounce row; COLS=4 gives cols 1,2,1,2 so
  // enemies 0 and 2 can share a cell. SEED bits 16 and 18 set: e0 asks -1 at row 1, e2 -1.
  enemy_squad #(
    .N_ENEMY(4),
    .ROWS(6),
    .COLS(4),
    .TICK_DIV(4),
    .SEED(32'h0005_0000),
    .HIT_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hit_valid(hit_valid),
    .hit_row(hit_row),
    .hit_col(hit_col),
    .tick(tick),
    .enemy_row(enemy_row),
    .enemy_col(enemy_col),
    .enemy_alive(enemy_alive),
    .enemy_hit(enemy_hit),
    .kill_count(kill_count),
    .all_dead(all_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot(input logic [2:0] r, input logic [1:0] c);
    hit_valid = 1'b1;
    hit_row   = r;
    hit_col   = c;
  endtask

  initial begin
    rst = 1'b0; hit_valid = 1'b0; hit_row = '0; hit_col = '0;
    repeat (2) step();
    // reset rows 1,2,3,4 -> 12'h8D1; cols 1,2,1,2 -> 8'h99
    chk("rst_tick",  tick,        0);
    chk("rst_rows",  enemy_row,   12'h8D1);
    chk("rst_cols",  enemy_col,   8'h99);
    chk("rst_alive", enemy_alive, 4'hF);
    chk("rst_hit",   enemy_hit,   4'h0);
    chk("rst_kill",  kill_count,  0);
    chk("rst_dead",  all_dead,    0);
    rst = 1'b1;

    repeat (3) step();
    chk("tick_c3", tick, 0);
    step();
    chk("tick_c4", tick, 1);
    shoot(3'd2, 2'd2);                 // enemy 1 during the tick cycle
    step();
    chk("tick_c5", tick, 0);
    // e0 1->2 (bounce), e1 held at 2, e2 3->2, e3 4->3 (bounce) -> 12'h692
    chk("move1_rows", enemy_row,  12'h692);
    chk("hit1_hit",   enemy_hit,  4'b0010);
    chk("hit1_alive", enemy_alive, 4'hF);
    chk("hit1_kill",  kill_count, 1);
    shoot(3'd2, 2'd2);                 // enemy 1 already HIT: ignored
    step();
    chk("rehit_kill", kill_count, 1);
    chk("rehit_hit",  enemy_hit,  4'b0010);
    shoot(3'd2, 2'd1);                 // enemies 0 and 2 share (2,1)
    step();
    chk("dbl_kill", kill_count, 3);
    chk("dbl_hit",  enemy_hit,  4'b0111);
    shoot(3'd3, 2'd2);                 // enemy 3
    step();
    hit_valid = 1'b0;
    chk("hit3_kill", kill_count, 4);
    chk("hit3_hit",  enemy_hit,  4'hF);
    chk("tick_c8",   tick,       1);
    step();
    chk("frozen_rows", enemy_row, 12'h692);
    repeat (3) step();
    chk("tick_c12",   tick,     1);
    chk("c12_dead",   all_dead, 0);
    chk("c12_hit",    enemy_hit, 4'hF);
    step();
    chk("c13_dead",   all_dead,    1);
    chk("c13_alive",  enemy_alive, 4'h0);
    chk("c13_hit",    enemy_hit,   4'h0);
    shoot(3'd2, 2'd2);                 // shot at a DEAD enemy's cell
    step();
    hit_valid = 1'b0;
    chk("dead_kill",  kill_count,  4);
    chk("dead_alive", enemy_alive, 4'h0);
`ifdef ENEMY_RESPAWN_EN
    repeat (30) step();
    chk("resp_pre_alive", enemy_alive, 4'h0);
    step();
    chk("resp_alive", enemy_alive, 4'hF);
    chk("resp_rows",  enemy_row,   12'h8D1);
    chk("resp_dead",  all_dead,    0);
`else
    repeat (31) step();
    chk("term_dead",  all_dead,    1);
    chk("term_alive", enemy_alive, 4'h0);
`endif

    // second run: reset asserted mid-cycle while enemy 0 is HIT
    rst = 1'b0;
    step();
    rst = 1'b1;
    shoot(3'd1, 2'd1);
    step();
    hit_valid = 1'b0;
    chk("p2_hit",  enemy_hit,  4'b0001);
    chk("p2_kill", kill_count, 1);
    #2;
    rst = 1'b0;
    shoot(3'd2, 2'd2);
    #1;
    chk("ar_hit",   enemy_hit,   4'h0);
    chk("ar_kill",  kill_count,  0);
    chk("ar_alive", enemy_alive, 4'hF);
    chk("ar_rows",  enemy_row,   12'h8D1);
    chk("ar_tick",  tick,        0);
    chk("ar_dead",  all_dead,    0);
    step();
    chk("ar_hold_hit", enemy_hit, 4'h0);
    hit_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("p2_tick_c3", tick, 0);
    step();
    chk("p2_tick_c4", tick, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_squad.md
ENEMY_SQUAD -- requirements
Module: enemy_squad

Interface
REQ-001 Parameter N_ENEMY, default 4: number of independent enemies, range 1..8.
REQ-002 Parameter ROWS, default 8: grid rows, range 4..16; ROW_W = clog2(ROWS).
REQ-003 Parameter COLS, default 8: grid columns, range 4..16; COL_W = clog2(COLS).
REQ-004 Parameter TICK_DIV, default 12500000: clk cycles per movement tick, minimum 2.
REQ-005 Parameter SEED, default 32'h0000_0001: PRNG reset value.
REQ-006 Parameter HIT_TICKS, default 2: ticks an enemy remains in HIT before DEAD.
REQ-007 clk  in  1  system clock; all state on posedge clk.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 hit_valid  in  1  one-cycle strobe: a player shot lands at hit_row/hit_col.
REQ-010 hit_row  in  ROW_W  shot row.
REQ-011 hit_col  in  COL_W  shot column.
REQ-012 tick  out  1  one-cycle pulse per movement tick.
REQ-013 enemy_row  out  N_ENEMY*ROW_W  packed rows; enemy i at slice i.
REQ-014 enemy_col  out  N_ENEMY*COL_W  packed columns.
REQ-015 enemy_alive  out  N_ENEMY  1 = enemy in ALIVE or HIT state (drawn).
REQ-016 enemy_hit  out  N_ENEMY  1 = enemy in HIT state (display blinks it).
REQ-017 kill_count  out  8  count of enemies that entered HIT since reset.
REQ-018 all_dead  out  1  1 when every enemy is in DEAD state.

Function
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 and assert tick for one cycle on the wrap to 0.
REQ-020 A 32-bit LCG SHALL update once per tick: rnd <= rnd*1103515245 + 12345 (mod 2^32).
REQ-021 On tick, each ALIVE enemy i SHALL read direction bit rnd[16+i] of the pre-update value: 0 = row+1, 1 = row-1.
REQ-022 Row bounce: at row ROWS-2 a +1 request SHALL become -1; at row 1 a -1 request SHALL become +1; rows 0 and ROWS-1 are never occupied.
REQ-023 Columns SHALL be fixed at col_i = 1 + (i mod (COLS-2)) and never change.
REQ-024 Per-enemy FSM: ALIVE -> HIT on matching hit; HIT -> DEAD after HIT_TICKS ticks; DEAD holds, except as in REQ-034.
REQ-025 Match SHALL be hit_valid & ALIVE & hit_row==row_i & hit_col==col_i, compared against the pre-move position.
REQ-026 Hit and tick in the same cycle: hit SHALL win; a matched enemy SHALL NOT move; unmatched enemies SHALL move normally.
REQ-027 Several enemies matching one hit SHALL all enter HIT; kill_count SHALL add the number matched.
REQ-028 kill_count SHALL saturate at 255.
REQ-029 HIT and DEAD enemies SHALL NOT move and SHALL ignore hits.
REQ-030 All outputs SHALL be registered; state changes are visible one cycle after the causing edge.

Reset
REQ-031 On rst low: tick counter 0, tick 0, rnd SEED, all enemies ALIVE, row_i = 1 + (i mod (ROWS-2)), enemy_hit 0, kill_count 0, all_dead 0.
REQ-032 Reset asserted mid-operation SHALL take effect immediately, regardless of hit or tick activity.
REQ-033 The first tick after reset release SHALL occur TICK_DIV cycles later.

Configuration
REQ-034 With ENEMY_RESPAWN_EN defined: a DEAD enemy SHALL return to ALIVE at its reset row after RESPAWN_TICKS ticks (parameter, default 8); while this macro is defined, all_dead is asserted only in the cycles when every enemy is DEAD simultaneously.
REQ-035 Without ENEMY_RESPAWN_EN: DEAD is terminal until reset; the RESPAWN_TICKS parameter and its counters SHALL NOT exist.

Structure
REQ-036 Shared package enemy_pkg SHALL hold the FSM state enum (ALIVE, HIT, DEAD) and the LCG multiplier and increment constants.
REQ-037 Per-enemy FSM, position and timers SHALL be a sub-module enemy_unit, instantiated N_ENEMY times via generate; tick, PRNG and kill counter stay at top level.

Verification
REQ-038 TICK_DIV=4, reset release -> tick pulses on cycles 4, 8, 12; rows start 1, 2, 3, 4 (N_ENEMY=4).
REQ-039 Force rnd so that enemy 0 requests -1 at row 1 -> row becomes 2 at the next tick.
REQ-040 hit_valid with hit_row=2, hit_col=2 (enemy 1) in a tick cycle -> enemy 1 stays at row 2; enemy_hit[1]=1; kill_count=1; enemy 1 becomes DEAD 2 ticks later.
REQ-041 Repeat a hit at a DEAD enemy's position -> no change in kill_count.
REQ-042 Kill all 4 enemies -> all_dead=1; with ENEMY_RESPAWN_EN, 8 ticks after the last enemy dies, that enemy is ALIVE at its reset row.
REQ-043 Assert rst mid-HIT -> all state equals REQ-031 values asynchronously.
